// File: rtl/fse_decim_if.sv
// Bus bundle for fse_decim: input sample stream, tap programming port and the
// symbol-rate equalized output with its status strobes.
interface fse_decim_if #(
  parameter int NUM_TAPS = 15,
  parameter int OS       = 2,
  parameter int NBT_IN   = 8,
  parameter int NBT_TAPS = 10,
  parameter int NBT_OUT  = 12
);
  localparam int PW = (OS > 1) ? $clog2(OS) : 1;
  localparam int AW = $clog2(NUM_TAPS);

  logic                       i_en_rx;
  logic                       i_valid;
  logic signed [NBT_IN-1:0]   i_data_I;
  logic signed [NBT_IN-1:0]   i_data_Q;
  logic [PW-1:0]              i_dec_phase;
  logic                       i_round;
  logic                       i_tap_we;
  logic [AW-1:0]              i_tap_addr;
  logic signed [NBT_TAPS-1:0] i_tap_I;
  logic signed [NBT_TAPS-1:0] i_tap_Q;
  logic                       i_tap_commit;
  logic signed [NBT_OUT-1:0]  o_data_I;
  logic signed [NBT_OUT-1:0]  o_data_Q;
  logic                       o_valid;
  logic                       o_sat;
  logic                       o_commit_done;
  logic [15:0]                o_sat_cnt;

  modport master (
    output i_en_rx, i_valid, i_data_I, i_data_Q, i_dec_phase, i_round,
           i_tap_we, i_tap_addr, i_tap_I, i_tap_Q, i_tap_commit,
    input  o_data_I, o_data_Q, o_valid, o_sat, o_commit_done, o_sat_cnt
  );

  modport slave (
    input  i_en_rx, i_valid, i_data_I, i_data_Q, i_dec_phase, i_round,
           i_tap_we, i_tap_addr, i_tap_I, i_tap_Q, i_tap_commit,
    output o_data_I, o_data_Q, o_valid, o_sat, o_commit_done, o_sat_cnt
  );
endinterface

// File: rtl/fse_decim.sv
// Decimating complex FIR equalizer: double-buffered taps committed on a launch
// edge, 4-stage multiply/add pipeline, round/truncate and saturating output.
module fse_decim #(
  parameter int NUM_TAPS = 15,
  parameter int OS       = 2,
  parameter int NBT_IN   = 8,
  parameter int NBF_IN   = 7,
  parameter int NBT_TAPS = 10,
  parameter int NBF_TAPS = 7,
  parameter int NBT_OUT  = 12,
  parameter int NBF_OUT  = 9
) (
  input logic       clk,
  input logic       i_reset_n,
  fse_decim_if.slave bus
);
  localparam int PW     = (OS > 1) ? $clog2(OS) : 1;
  localparam int AW     = $clog2(NUM_TAPS);
  localparam int PRW    = NBT_IN + NBT_TAPS;
  localparam int SW     = PRW + $clog2(NUM_TAPS) + 1;
  localparam int DROP   = NBF_IN + NBF_TAPS - NBF_OUT;
  localparam int HALF   = NUM_TAPS / 2;
  localparam int CENTRE = NUM_TAPS / 2;
  localparam logic signed [NBT_TAPS-1:0] TAP_ONE  = {{(NBT_TAPS-1){1'b0}}, 1'b1} << NBF_TAPS;
  localparam logic signed [SW-1:0]       RND_HALF = (DROP > 0) ? SW'(2 ** (DROP - 1)) : '0;
  localparam logic signed [SW-1:0]       OUT_MAX  = SW'((2 ** (NBT_OUT - 1)) - 1);
  localparam logic signed [SW-1:0]       OUT_MIN  = ~OUT_MAX;

  logic signed [NBT_IN-1:0]   sr_i_r  [NUM_TAPS];
  logic signed [NBT_IN-1:0]   sr_q_r  [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] shd_i_r [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] shd_q_r [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] act_i_r [NUM_TAPS];
  logic signed [NBT_TAPS-1:0] act_q_r [NUM_TAPS];
  // Product/sum index: 0 = sI*tI, 1 = sQ*tQ, 2 = sI*tQ, 3 = sQ*tI
  logic signed [PRW-1:0]      prod_r  [4][NUM_TAPS];
  logic signed [SW-1:0]       half_s  [2][4];
  logic signed [SW-1:0]       half_r  [2][4];
  logic signed [SW-1:0]       full_r  [4];
  logic [PW-1:0]              phase_r;
  logic [PW-1:0]              phase_nxt_s;
  logic                       pend_r, v0_r, v1_r, v2_r, v3_r;
  logic                       accept_s, launch_s, copy_s, we_ok_s;
  logic signed [SW-1:0]       y_i_s, y_q_s, r_i_s, r_q_s, q_i_s, q_q_s;
  logic [NBT_OUT:0]           s_i_s, s_q_s;

  // Clip to the output range; MSB of the result flags a clip.
  function automatic logic [NBT_OUT:0] sat_f(input logic signed [SW-1:0] v);
    logic [NBT_OUT:0] r;
    if (v > OUT_MAX) begin
      r = {1'b1, OUT_MAX[NBT_OUT-1:0]};
    end else if (v < OUT_MIN) begin
      r = {1'b1, OUT_MIN[NBT_OUT-1:0]};
    end else begin
      r = {1'b0, v[NBT_OUT-1:0]};
    end
    return r;
  endfunction

  // Per-cycle acceptance, launch and bank-copy decisions.
  always_comb begin
    accept_s = bus.i_en_rx & bus.i_valid;
    launch_s = accept_s & (phase_r == bus.i_dec_phase);
    copy_s   = launch_s & pend_r;
    we_ok_s  = bus.i_tap_we & (int'(bus.i_tap_addr) < NUM_TAPS);
    if (phase_r == PW'(OS - 1)) begin
      phase_nxt_s = '0;
    end else begin
      phase_nxt_s = phase_r + PW'(1);
    end
  end

  // Shadow and active tap banks; a write landing on the copy edge is forwarded.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shd_i_r[k] <= (k == CENTRE) ? TAP_ONE : '0;
        shd_q_r[k] <= '0;
        act_i_r[k] <= (k == CENTRE) ? TAP_ONE : '0;
        act_q_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (we_ok_s && (bus.i_tap_addr == AW'(k))) begin
          shd_i_r[k] <= bus.i_tap_I;
          shd_q_r[k] <= bus.i_tap_Q;
        end
        if (copy_s) begin
          if (we_ok_s && (bus.i_tap_addr == AW'(k))) begin
            act_i_r[k] <= bus.i_tap_I;
            act_q_r[k] <= bus.i_tap_Q;
          end else begin
            act_i_r[k] <= shd_i_r[k];
            act_q_r[k] <= shd_q_r[k];
          end
        end
      end
    end
  end

  // Commit-pending flag; survives flush.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      pend_r <= 1'b0;
    end else if (bus.i_tap_commit) begin
      pend_r <= 1'b1;
    end else if (copy_s) begin
      pend_r <= 1'b0;
    end
  end

  // Sample shifter, phase counter, launch flag and commit-done pulse.
  always_ff @(posedge clk) begin
    if (!i_reset_n || !bus.i_en_rx) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        sr_i_r[k] <= '0;
        sr_q_r[k] <= '0;
      end
      phase_r           <= '0;
      v0_r              <= 1'b0;
      bus.o_commit_done <= 1'b0;
    end else begin
      v0_r              <= launch_s;
      bus.o_commit_done <= copy_s;
      if (accept_s) begin
        sr_i_r[0] <= bus.i_data_I;
        sr_q_r[0] <= bus.i_data_Q;
        for (int k = 1; k < NUM_TAPS; k++) begin
          sr_i_r[k] <= sr_i_r[k-1];
          sr_q_r[k] <= sr_q_r[k-1];
        end
        phase_r <= phase_nxt_s;
      end
    end
  end

  // Valid pipeline for stages E2..E4.
  always_ff @(posedge clk) begin
    if (!i_reset_n || !bus.i_en_rx) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
    end else begin
      v1_r <= v0_r;
      v2_r <= v1_r;
      v3_r <= v2_r;
    end
  end

  // E1: full-precision products.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      for (int j = 0; j < 4; j++) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          prod_r[j][k] <= '0;
        end
      end
    end else if (v0_r) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        prod_r[0][k] <= PRW'(sr_i_r[k]) * PRW'(act_i_r[k]);
        prod_r[1][k] <= PRW'(sr_q_r[k]) * PRW'(act_q_r[k]);
        prod_r[2][k] <= PRW'(sr_i_r[k]) * PRW'(act_q_r[k]);
        prod_r[3][k] <= PRW'(sr_q_r[k]) * PRW'(act_i_r[k]);
      end
    end
  end

  // Lower/upper half-tree sums of each product type.
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      for (int j = 0; j < 4; j++) begin
        half_s[h][j] = '0;
      end
    end
    for (int k = 0; k < NUM_TAPS; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (k < HALF) begin
          half_s[0][j] = half_s[0][j] + SW'(prod_r[j][k]);
        end else begin
          half_s[1][j] = half_s[1][j] + SW'(prod_r[j][k]);
        end
      end
    end
  end

  // E2 partial sums and E3 full convolution sums.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      for (int j = 0; j < 4; j++) begin
        half_r[0][j] <= '0;
        half_r[1][j] <= '0;
        full_r[j]    <= '0;
      end
    end else begin
      if (v1_r) begin
        half_r <= half_s;
      end
      if (v2_r) begin
        for (int j = 0; j < 4; j++) begin
          full_r[j] <= half_r[0][j] + half_r[1][j];
        end
      end
    end
  end

  // Complex combine, optional half-up rounding, LSB drop and saturation.
  always_comb begin
    y_i_s = full_r[0] - full_r[1];
    y_q_s = full_r[2] + full_r[3];
    if (bus.i_round) begin
      r_i_s = y_i_s + RND_HALF;
      r_q_s = y_q_s + RND_HALF;
    end else begin
      r_i_s = y_i_s;
      r_q_s = y_q_s;
    end
    q_i_s = r_i_s >>> DROP;
    q_q_s = r_q_s >>> DROP;
    s_i_s = sat_f(q_i_s);
    s_q_s = sat_f(q_q_s);
  end

  // E4: output registers and saturation counter.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      bus.o_data_I  <= '0;
      bus.o_data_Q  <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_sat     <= 1'b0;
      bus.o_sat_cnt <= 16'd0;
    end else if (!bus.i_en_rx) begin
      bus.o_valid <= 1'b0;
      bus.o_sat   <= 1'b0;
    end else begin
      bus.o_valid <= v3_r;
      if (v3_r) begin
        bus.o_data_I <= s_i_s[NBT_OUT-1:0];
        bus.o_data_Q <= s_q_s[NBT_OUT-1:0];
        bus.o_sat    <= s_i_s[NBT_OUT] | s_q_s[NBT_OUT];
        if ((s_i_s[NBT_OUT] | s_q_s[NBT_OUT]) && (bus.o_sat_cnt != 16'hFFFF)) begin
          bus.o_sat_cnt <= bus.o_sat_cnt + 16'd1;
        end
      end else begin
        bus.o_sat <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fse_decim.sv
// Directed bench for fse_decim: table of single-tap / all-tap vectors plus
// hand-written latency, commit-alignment, flush and reset sequences.
module tb_fse_decim;
  localparam int NUM_TAPS = 15;

  typedef struct {
    string name;
    bit    all_taps;
    int    ti, tq, si, sq;
    bit    rnd;
    int    ei, eq;
    bit    es;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fse_decim_if #(.NUM_TAPS(15), .OS(2), .NBT_IN(8), .NBT_TAPS(10), .NBT_OUT(12)) bus ();

  fse_decim #(
    .NUM_TAPS(15), .OS(2), .NBT_IN(8), .NBF_IN(7), .NBT_TAPS(10), .NBF_TAPS(7),
    .NBT_OUT(12), .NBF_OUT(9)
  ) dut (
    .clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  int   n_checks, n_errors;
  int   nv, nsat, ncd, last_i, last_q;
  int   exp_cnt;
  vec_t vecs [11];

  function automatic vec_t mk(input string n, input bit a, input int ti, input int tq,
                              input int si, input int sq, input bit r,
                              input int ei, input int eq, input bit es);
    vec_t v;
    v.name = n; v.all_taps = a; v.ti = ti; v.tq = tq; v.si = si; v.sq = sq;
    v.rnd = r; v.ei = ei; v.eq = eq; v.es = es;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    nv = 0; nsat = 0; ncd = 0;
  endtask

  task automatic sample();
    if (bus.o_valid) begin
      nv++;
      if (bus.o_sat) nsat++;
      last_i = int'(bus.o_data_I);
      last_q = int'(bus.o_data_Q);
    end
    if (bus.o_commit_done) ncd++;
  endtask

  task automatic feed(input int n, input int si, input int sq, input bit vld);
    for (int c = 0; c < n; c++) begin
      bus.i_valid  = vld;
      bus.i_data_I = 8'(si);
      bus.i_data_Q = 8'(sq);
      tick();
      sample();
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic write_taps(input bit all, input int ti, input int tq);
    for (int k = 0; k < NUM_TAPS; k++) begin
      bus.i_tap_we   = 1'b1;
      bus.i_tap_addr = 4'(k);
      bus.i_tap_I    = (all || k == 7) ? 10'(ti) : 10'(0);
      bus.i_tap_Q    = (all || k == 7) ? 10'(tq) : 10'(0);
      tick();
    end
    bus.i_tap_we = 1'b0;
  endtask

  task automatic commit();
    bus.i_tap_commit = 1'b1;
    tick();
    bus.i_tap_commit = 1'b0;
  endtask

  task automatic flush();
    bus.i_en_rx = 1'b0;
    tick();
    bus.i_en_rx = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, d9, v10, d11, cd_at, ncd_b, d47, d49i, d49q, bad_old, bad_new, idx;
    n_checks = 0; n_errors = 0; exp_cnt = 0;
    nv = 0; nsat = 0; ncd = 0; last_i = 0; last_q = 0;

    vecs[0]  = mk("identity",   1'b0, 128,   0,   64,   0, 1'b0,   256,    0, 1'b0);
    vecs[1]  = mk("jtap_q_in",  1'b0,   0, 128,    0,  64, 1'b0,  -256,    0, 1'b0);
    vecs[2]  = mk("jtap_i_in",  1'b0,   0, 128,   64,   0, 1'b0,     0,  256, 1'b0);
    vecs[3]  = mk("trunc_half", 1'b0,   4,   0,    4,   0, 1'b0,     0,    0, 1'b0);
    vecs[4]  = mk("round_half", 1'b0,   4,   0,    4,   0, 1'b1,     1,    0, 1'b0);
    vecs[5]  = mk("trunc_neg",  1'b0,  -4,   0,    4,   0, 1'b0,    -1,    0, 1'b0);
    vecs[6]  = mk("round_neg",  1'b0,  -4,   0,    4,   0, 1'b1,     0,    0, 1'b0);
    vecs[7]  = mk("sat_pos",    1'b1, 511,   0,  127,   0, 1'b0,  2047,    0, 1'b1);
    vecs[8]  = mk("sat_neg",    1'b1, 511,   0, -128,   0, 1'b0, -2048,    0, 1'b1);
    vecs[9]  = mk("sat_q",      1'b1,   0, 511,  127,   0, 1'b0,     0, 2047, 1'b1);
    vecs[10] = mk("mixed",      1'b0,  64, -32,   32, -16, 1'b0,    48,  -64, 1'b0);

    rst_n = 1'b0;
    bus.i_en_rx = 1'b0; bus.i_valid = 1'b0; bus.i_data_I = 8'sd0; bus.i_data_Q = 8'sd0;
    bus.i_dec_phase = 1'b1; bus.i_round = 1'b0; bus.i_tap_we = 1'b0; bus.i_tap_addr = 4'd0;
    bus.i_tap_I = 10'sd0; bus.i_tap_Q = 10'sd0; bus.i_tap_commit = 1'b0;
    tick();
    tick();
    check("reset_o_valid", int'(bus.o_valid), 0);
    check("reset_o_data_I", int'(bus.o_data_I), 0);
    check("reset_o_sat_cnt", int'(bus.o_sat_cnt), 0);
    check("reset_o_commit_done", int'(bus.o_commit_done), 0);
    rst_n = 1'b1;
    bus.i_en_rx = 1'b1;

    // Latency and centre-tap fill with the reset taps.
    first = -1; d9 = -99; v10 = -99; d11 = -99;
    for (int i = 0; i < 14; i++) begin
      bus.i_valid = 1'b1; bus.i_data_I = 8'sd64; bus.i_data_Q = 8'sd0;
      tick();
      if (bus.o_valid && first < 0) first = i;
      if (i == 9)  d9  = int'(bus.o_data_I);
      if (i == 10) v10 = int'(bus.o_valid);
      if (i == 11) d11 = int'(bus.o_data_I);
    end
    bus.i_valid = 1'b0;
    check("latency_first_valid", first, 5);
    check("prefill_data_I", d9, 0);
    check("valid_every_2nd", v10, 0);
    check("identity_reset_taps_I", d11, 256);

    // Phase 0 selects the first sample after flush.
    flush();
    bus.i_dec_phase = 1'b0;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      bus.i_valid = 1'b1;
      tick();
      if (bus.o_valid && first < 0) first = i;
    end
    bus.i_valid = 1'b0;
    check("phase0_first_valid", first, 4);
    bus.i_dec_phase = 1'b1;
    feed(8, 0, 0, 1'b0);

    for (int v = 0; v < 11; v++) begin
      bus.i_round = vecs[v].rnd;
      write_taps(vecs[v].all_taps, vecs[v].ti, vecs[v].tq);
      commit();
      flush();
      clr();
      feed(40, vecs[v].si, vecs[v].sq, 1'b1);
      feed(8, 0, 0, 1'b0);
      if (vecs[v].es) exp_cnt += 20;
      check({vecs[v].name, "_I"}, last_i, vecs[v].ei);
      check({vecs[v].name, "_Q"}, last_q, vecs[v].eq);
      check({vecs[v].name, "_nvalid"}, nv, 20);
      check({vecs[v].name, "_nsat"}, nsat, vecs[v].es ? 20 : 0);
      check({vecs[v].name, "_ncommit"}, ncd, 1);
      check({vecs[v].name, "_sat_cnt"}, int'(bus.o_sat_cnt), exp_cnt);
    end

    // Symbol-aligned commit: last shadow write shares its cycle with the commit.
    bus.i_round = 1'b0;
    flush();
    cd_at = -1; ncd_b = 0; d47 = -999; d49i = -999; d49q = -999; bad_old = 0; bad_new = 0;
    for (int i = 0; i < 60; i++) begin
      bus.i_valid = 1'b1; bus.i_data_I = 8'sd32; bus.i_data_Q = -8'sd16;
      if (i >= 30 && i < 45) begin
        idx = i - 30;
        bus.i_tap_we   = 1'b1;
        bus.i_tap_addr = (idx < 7) ? 4'(idx) : ((idx < 14) ? 4'(idx + 1) : 4'd7);
        bus.i_tap_I    = (idx == 14) ? 10'sd128 : 10'sd0;
        bus.i_tap_Q    = 10'sd0;
      end else begin
        bus.i_tap_we = 1'b0;
      end
      bus.i_tap_commit = (i == 44);
      tick();
      if (bus.o_commit_done) begin ncd_b++; cd_at = i; end
      if (bus.o_valid) begin
        if (i >= 30 && i <= 47 && (int'(bus.o_data_I) != 48 || int'(bus.o_data_Q) != -64)) bad_old++;
        if (i >= 49 && (int'(bus.o_data_I) != 128 || int'(bus.o_data_Q) != -64)) bad_new++;
      end
      if (i == 47) d47 = int'(bus.o_data_I);
      if (i == 49) begin d49i = int'(bus.o_data_I); d49q = int'(bus.o_data_Q); end
    end
    bus.i_valid = 1'b0; bus.i_tap_we = 1'b0; bus.i_tap_commit = 1'b0;
    check("commit_done_cycle", cd_at, 45);
    check("commit_done_count", ncd_b, 1);
    check("commit_last_old_I", d47, 48);
    check("commit_first_new_I", d49i, 128);
    check("commit_first_new_Q", d49q, -64);
    check("commit_old_outputs_bad", bad_old, 0);
    check("commit_new_outputs_bad", bad_new, 0);

    // One-cycle flush with outputs in flight.
    feed(20, 32, -16, 1'b1);
    clr();
    bus.i_en_rx = 1'b0; bus.i_valid = 1'b1;
    tick();
    sample();
    bus.i_en_rx = 1'b1; bus.i_valid = 1'b0;
    feed(14, 0, 0, 1'b0);
    check("flush_no_valid", nv, 0);
    check("flush_sat_cnt_kept", int'(bus.o_sat_cnt), exp_cnt);
    clr();
    feed(40, 32, -16, 1'b1);
    feed(8, 0, 0, 1'b0);
    check("flush_taps_kept_I", last_i, 128);
    check("flush_taps_kept_Q", last_q, -64);
    check("flush_nvalid", nv, 20);

    // Reset pulse restores zeros and the centre 1.0 tap.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_o_data_I", int'(bus.o_data_I), 0);
    check("rst2_o_data_Q", int'(bus.o_data_Q), 0);
    check("rst2_o_valid", int'(bus.o_valid), 0);
    check("rst2_o_sat", int'(bus.o_sat), 0);
    check("rst2_o_sat_cnt", int'(bus.o_sat_cnt), 0);
    clr();
    feed(40, 64, 0, 1'b1);
    feed(8, 0, 0, 1'b0);
    check("rst2_identity_I", last_i, 256);
    check("rst2_identity_Q", last_q, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
